// File: rtl/workout_sequencer.sv
// Workout phase controller: runs IDLE -> WORK -> REST -> ... -> DONE on an internal
// 1 Hz prescaler and emits one-cycle buzzer events on every phase entry.
//
// state | meaning
// IDLE  | waiting for start; prescaler held at 0, exercise number 0
// WORK  | exercise in progress, counting down WORK_SEC
// REST  | pause between exercises, counting down REST_SEC
// DONE  | workout finished, held for DONE_SEC before returning to IDLE
module workout_sequencer #(
  parameter int CLK_HZ          = 40_000_000,
  parameter bit SIM_SPEEDUP     = 1'b0,
  parameter int SIM_TICK_CYCLES = 100,
  parameter int WORK_SEC        = 30,
  parameter int REST_SEC        = 10,
  parameter int DONE_SEC        = 5
) (
  input  logic       clk_40MHz,
  input  logic       system_reset_n,
  input  logic       start_pulse,
  input  logic       skip_pulse,
  input  logic [8:0] total_exercises,
  output logic [1:0] workout_state,
  output logic [8:0] current_exercise_num,
  output logic [6:0] countdown_seconds,
  output logic       tick_1hz,
  output logic       buzz_evt,
  output logic [1:0] buzz_kind
);

  localparam int PRESCALE = SIM_SPEEDUP ? SIM_TICK_CYCLES : CLK_HZ;
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [6:0] WORK_LEN = 7'(WORK_SEC);
  localparam logic [6:0] REST_LEN = 7'(REST_SEC);
  localparam logic [6:0] DONE_LEN = 7'(DONE_SEC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WORK = 2'b01,
    ST_REST = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [8:0]       num_q, num_d;
  logic [8:0]       total_q, total_d;
  logic [6:0]       sec_q, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             buzz_q, buzz_d;
  logic [1:0]       kind_q, kind_d;
  logic [6:0]       cd_q, cd_d;
  logic             entry;
  logic             sec_last;

  assign sec_last = (sec_q == 7'd1);

  always_ff @(posedge clk_40MHz or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      total_q <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      buzz_q  <= 1'b0;
      kind_q  <= '0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      total_q <= total_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      buzz_q  <= buzz_d;
      kind_q  <= kind_d;
      cd_q    <= cd_d;
    end
  end

  // tick_q mirrors "prescaler at P-1" for the current cycle, so it doubles as the FSM tick
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    total_d = total_q;
    sec_d   = sec_q;
    entry   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse && (total_exercises != 9'd0)) begin
          total_d = total_exercises;
          num_d   = 9'd1;
          sec_d   = WORK_LEN;
          state_d = ST_WORK;
          entry   = 1'b1;
        end
      end
      ST_WORK: begin
        if (skip_pulse) begin
          entry = 1'b1;
          if (num_q == total_q) begin
            state_d = ST_DONE;
            sec_d   = DONE_LEN;
          end else begin
            num_d = num_q + 9'd1;
            sec_d = WORK_LEN;
          end
        end else if (tick_q) begin
          if (sec_last) begin
            entry = 1'b1;
            if (num_q == total_q) begin
              state_d = ST_DONE;
              sec_d   = DONE_LEN;
            end else begin
              state_d = ST_REST;
              sec_d   = REST_LEN;
            end
          end else begin
            sec_d = sec_q - 7'd1;
          end
        end
      end
      ST_REST: begin
        if (skip_pulse || (tick_q && sec_last)) begin
          state_d = ST_WORK;
          num_d   = num_q + 9'd1;
          sec_d   = WORK_LEN;
          entry   = 1'b1;
        end else if (tick_q) begin
          sec_d = sec_q - 7'd1;
        end
      end
      ST_DONE: begin
        if (start_pulse || (tick_q && sec_last)) begin
          state_d = ST_IDLE;
          num_d   = 9'd0;
          sec_d   = 7'd0;
        end else if (tick_q) begin
          sec_d = sec_q - 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (!entry && (state_d != ST_IDLE)) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (state_d != ST_IDLE) && (cnt_d == CNT_LAST);
    buzz_d = entry;
    kind_d = entry ? state_d : 2'b00;
    cd_d   = ((state_d == ST_WORK) || (state_d == ST_REST)) ? sec_d : 7'd0;
  end

  assign workout_state        = state_q;
  assign current_exercise_num = num_q;
  assign countdown_seconds    = cd_q;
  assign tick_1hz             = tick_q;
  assign buzz_evt             = buzz_q;
  assign buzz_kind            = kind_q;

endmodule

// File: tb/tb_workout_sequencer.sv
// Self-checking bench for workout_sequencer: directed scenarios plus randomized
// start/skip/total traffic compared against a timestamp-based phase model.
module tb_workout_sequencer;

  localparam int P  = 100;
  localparam int WS = 5;
  localparam int RS = 3;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       skip = 1'b0;
  logic [8:0] total = '0;
  logic [1:0] workout_state;
  logic [8:0] current_exercise_num;
  logic [6:0] countdown_seconds;
  logic       tick_1hz;
  logic       buzz_evt;
  logic [1:0] buzz_kind;
  logic [21:0] obs;

  int checks = 0;
  int errors = 0;

  workout_sequencer #(
    .CLK_HZ(40_000_000), .SIM_SPEEDUP(1'b1), .SIM_TICK_CYCLES(P),
    .WORK_SEC(WS), .REST_SEC(RS), .DONE_SEC(DS)
  ) dut (
    .clk_40MHz(clk), .system_reset_n(rst_n), .start_pulse(start), .skip_pulse(skip),
    .total_exercises(total), .workout_state(workout_state),
    .current_exercise_num(current_exercise_num), .countdown_seconds(countdown_seconds),
    .tick_1hz(tick_1hz), .buzz_evt(buzz_evt), .buzz_kind(buzz_kind)
  );

  always #5 clk = ~clk;

  assign obs = {workout_state, current_exercise_num, countdown_seconds, tick_1hz, buzz_evt, buzz_kind};

  // Reference model: a phase is described by its kind and the cycle it began;
  // countdown and tick follow from elapsed time by plain arithmetic.
  int m_state, m_num, m_total, m_entry, m_cyc, m_kind;
  logic m_buzz;

  function automatic int phase_len(int s);
    case (s)
      1: return WS;
      2: return RS;
      3: return DS;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_tick_at(int c);
    return (m_state != 0) && (((c - m_entry) % P) == P - 1);
  endfunction

  function automatic int m_left(int c);
    return phase_len(m_state) - (c - m_entry) / P;
  endfunction

  function automatic int m_cd();
    return (m_state == 1 || m_state == 2) ? m_left(m_cyc) : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_num = 0; m_total = 0; m_entry = 0; m_cyc = 0; m_kind = 0; m_buzz = 1'b0;
  endtask

  task automatic m_enter(int s);
    m_state = s; m_entry = m_cyc + 1; m_buzz = 1'b1; m_kind = s;
  endtask

  task automatic model_update(logic st, logic sk, int tot);
    logic last;
    last = m_tick_at(m_cyc) && (m_left(m_cyc) == 1);
    m_buzz = 1'b0; m_kind = 0;
    case (m_state)
      0: if (st && tot != 0) begin m_total = tot; m_num = 1; m_enter(1); end
      1: begin
        if (sk) begin
          if (m_num == m_total) m_enter(3);
          else begin m_num++; m_enter(1); end
        end else if (last) begin
          if (m_num == m_total) m_enter(3);
          else m_enter(2);
        end
      end
      2: if (sk || last) begin m_num++; m_enter(1); end
      3: if (st || last) begin m_state = 0; m_num = 0; end
      default: m_state = 0;
    endcase
    m_cyc++;
  endtask

  // drive one cycle of pulses, sampled at the next rising edge; returns 1 ns after it
  task automatic step(input logic st, input logic sk);
    start = st; skip = sk;
    @(posedge clk);
    model_update(st, sk, int'(total));
    #1;
    start = 1'b0; skip = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; skip = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    total = 9'd3;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs !== 22'd0) begin errors++; $display("FAIL idle_quiet cyc %0d got %h want 0", i, obs); end
    end
  endtask

  task automatic test_invalid_config();
    apply_reset();
    total = 9'd0;
    for (int i = 0; i < 1000; i++) begin
      step((i % 100) == 0, (i % 37) == 5);
      checks++;
      if ({workout_state, current_exercise_num, buzz_evt} !== 12'd0)
        begin errors++; $display("FAIL invalid_cfg cyc %0d state %0d num %0d buzz %0d want 0/0/0",
                                 i, workout_state, current_exercise_num, buzz_evt); end
    end
  endtask

  task automatic test_start_first_phase();
    apply_reset();
    total = 9'd3;
    step(1'b1, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind} !==
        {2'b01, 9'd1, 7'd5, 1'b1, 2'b01})
      begin errors++; $display("FAIL start_entry state %0d num %0d cd %0d buzz %0d kind %0d want 1/1/5/1/1",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind); end
    for (int i = 1; i < 500; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (tick_1hz !== ((i % 100) == 99) || workout_state !== 2'b01)
        begin errors++; $display("FAIL work_tick at +%0d tick %0d state %0d want tick %0d state 1",
                                 i, tick_1hz, workout_state, (i % 100) == 99); end
      if (i == 100) begin
        checks++;
        if (countdown_seconds !== 7'd4) begin errors++; $display("FAIL cd_after_tick got %0d want 4", countdown_seconds); end
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if ({workout_state, countdown_seconds, buzz_evt, buzz_kind} !== {2'b10, 7'd3, 1'b1, 2'b10})
      begin errors++; $display("FAIL rest_entry state %0d cd %0d buzz %0d kind %0d want 2/3/1/2",
                               workout_state, countdown_seconds, buzz_evt, buzz_kind); end
  endtask

  task automatic test_skips();
    apply_reset();
    total = 9'd5;
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind} !==
        {2'b01, 9'd2, 7'd5, 1'b1, 2'b01})
      begin errors++; $display("FAIL skip_work state %0d num %0d cd %0d buzz %0d kind %0d want 1/2/5/1/1",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind); end
    repeat (500) step(1'b0, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds} !== {2'b10, 9'd2, 7'd3})
      begin errors++; $display("FAIL to_rest state %0d num %0d cd %0d want 2/2/3",
                               workout_state, current_exercise_num, countdown_seconds); end
    repeat (30) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt} !== {2'b01, 9'd3, 7'd5, 1'b1})
      begin errors++; $display("FAIL skip_rest state %0d num %0d cd %0d buzz %0d want 1/3/5/1",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt); end
    repeat (99) step(1'b0, 1'b0);
    checks++;
    if (tick_1hz !== 1'b1) begin errors++; $display("FAIL tick_before_skip got %0d want 1", tick_1hz); end
    step(1'b0, 1'b1);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, tick_1hz} !== {2'b01, 9'd4, 7'd5, 1'b0})
      begin errors++; $display("FAIL skip_on_tick state %0d num %0d cd %0d tick %0d want 1/4/5/0",
                               workout_state, current_exercise_num, countdown_seconds, tick_1hz); end
    repeat (99) step(1'b0, 1'b0);
    checks++;
    if (countdown_seconds !== 7'd5) begin errors++; $display("FAIL reload_hold got %0d want 5", countdown_seconds); end
    step(1'b0, 1'b0);
    checks++;
    if (countdown_seconds !== 7'd4) begin errors++; $display("FAIL reload_dec got %0d want 4", countdown_seconds); end
  endtask

  task automatic test_completion();
    apply_reset();
    total = 9'd3;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (499) step(1'b0, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds} !== {2'b01, 9'd3, 7'd1})
      begin errors++; $display("FAIL last_work state %0d num %0d cd %0d want 1/3/1",
                               workout_state, current_exercise_num, countdown_seconds); end
    step(1'b0, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind} !==
        {2'b11, 9'd3, 7'd0, 1'b1, 2'b11})
      begin errors++; $display("FAIL done_entry state %0d num %0d cd %0d buzz %0d kind %0d want 3/3/0/1/3",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind); end
    repeat (199) step(1'b0, 1'b1);
    checks++;
    if (workout_state !== 2'b11) begin errors++; $display("FAIL done_hold got %0d want 3", workout_state); end
    step(1'b0, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, buzz_evt} !== {2'b00, 9'd0, 1'b0})
      begin errors++; $display("FAIL done_expire state %0d num %0d buzz %0d want 0/0/0",
                               workout_state, current_exercise_num, buzz_evt); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if ({workout_state, buzz_kind} !== {2'b11, 2'b11})
      begin errors++; $display("FAIL skip_last state %0d kind %0d want 3/3", workout_state, buzz_kind); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, buzz_evt} !== {2'b00, 9'd0, 1'b0})
      begin errors++; $display("FAIL start_in_done state %0d num %0d buzz %0d want 0/0/0",
                               workout_state, current_exercise_num, buzz_evt); end
    step(1'b0, 1'b0);
    checks++;
    if (workout_state !== 2'b00) begin errors++; $display("FAIL no_restart got %0d want 0", workout_state); end
  endtask

  task automatic test_ignored_inputs();
    apply_reset();
    total = 9'd3;
    step(1'b1, 1'b0);
    repeat (150) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt} !== {2'b01, 9'd1, 7'd4, 1'b0})
      begin errors++; $display("FAIL start_in_work state %0d num %0d cd %0d buzz %0d want 1/1/4/0",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt); end
    total = 9'd7;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (current_exercise_num !== 9'd3) begin errors++; $display("FAIL num_before_done got %0d want 3", current_exercise_num); end
    step(1'b0, 1'b1);
    checks++;
    if ({workout_state, current_exercise_num} !== {2'b11, 9'd3})
      begin errors++; $display("FAIL total_latched state %0d num %0d want 3/3", workout_state, current_exercise_num); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    total = 9'd2;
    step(1'b1, 1'b0);
    repeat (520) step(1'b0, 1'b0);
    checks++;
    if (workout_state !== 2'b10) begin errors++; $display("FAIL pre_reset_rest got %0d want 2", workout_state); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL async_reset got %h want 0", obs); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if ({workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind} !==
        {2'b01, 9'd1, 7'd5, 1'b1, 2'b01})
      begin errors++; $display("FAIL restart state %0d num %0d cd %0d buzz %0d kind %0d want 1/1/5/1/1",
                               workout_state, current_exercise_num, countdown_seconds, buzz_evt, buzz_kind); end
    repeat (500) step(1'b0, 1'b0);
    checks++;
    if ({workout_state, countdown_seconds} !== {2'b10, 7'd3})
      begin errors++; $display("FAIL restart_rest state %0d cd %0d want 2/3", workout_state, countdown_seconds); end
  endtask

  task automatic test_random();
    logic [21:0] exp;
    apply_reset();
    total = 9'($urandom_range(1, 4));
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) total = 9'($urandom_range(0, 4));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      exp = {2'(m_state), 9'(m_num), 7'(m_cd()), m_tick_at(m_cyc), m_buzz, 2'(m_kind)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random cyc %0d got %h want %h", i, obs, exp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_invalid_config();
    test_start_first_phase();
    test_skips();
    test_completion();
    test_ignored_inputs();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
